// File: rtl/alu_pkg.sv
// Shared encodings and FSM state type for the pipelined ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_FUN = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [2:0] FUNCT_ADD  = 3'b000;
  localparam logic [2:0] FUNCT_SUB  = 3'b100;
  localparam logic [2:0] FUNCT_AND  = 3'b011;
  localparam logic [2:0] FUNCT_OR   = 3'b010;
  localparam logic [2:0] FUNCT_NAND = 3'b110;
  localparam logic [2:0] FUNCT_NOR  = 3'b111;
  localparam logic [2:0] FUNCT_MUL  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/logic unit with carry, signed overflow and illegal-op decode.
// funct 101 is always reported illegal here; alu_pipe claims it when ALU_MUL_EN is defined.
module alu_core #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [2:0]       funct,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             illegal
);
  import alu_pkg::*;

  logic             is_sub_s;
  logic [WIDTH-1:0] opb_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;

  // Subtract is add of the inverted operand with a forced carry-in.
  assign is_sub_s = (op == OP_SUB) || ((op == OP_FUN) && (funct == FUNCT_SUB));
  assign opb_s    = is_sub_s ? ~b : b;
  assign cin_s    = is_sub_s ? 1'b1 : cin;
  assign sum_s    = {1'b0, a} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin_s};

  // Operation select and flag generation.
  always_comb begin
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum_s[WIDTH-1:0];
        cout     = sum_s[WIDTH];
        overflow = (a[WIDTH-1] == opb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_FUN: begin
        case (funct)
          FUNCT_ADD, FUNCT_SUB: begin
            result   = sum_s[WIDTH-1:0];
            cout     = sum_s[WIDTH];
            overflow = (a[WIDTH-1] == opb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
          end
          FUNCT_AND:  result = a & b;
          FUNCT_OR:   result = a | b;
          FUNCT_NAND: result = ~(a & b);
          FUNCT_NOR:  result = ~(a | b);
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, one-entry output register and illegal-op flag.
// Optional ALU_MUL_EN adds a WIDTH-cycle shift-add multiply on op=10 funct=101.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [2:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);
  import alu_pkg::*;

  alu_state_t       state_r, state_nx_s;
  logic             out_valid_r, cout_r, zero_r, overflow_r, illegal_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] core_result_s;
  logic             core_cout_s, core_ovf_s, core_ill_s;
  logic             accept_s, consume_s, is_mul_s, mul_done_s;
  logic [WIDTH-1:0] mul_result_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op       (op),
    .funct    (funct),
    .result   (core_result_s),
    .cout     (core_cout_s),
    .overflow (core_ovf_s),
    .illegal  (core_ill_s)
  );

  assign in_ready  = !reset && (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid_r && out_ready;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] prod_r, mcand_r, mplier_r, prod_next_s;
  logic             mul_last_s;

  assign is_mul_s     = (op == OP_FUN) && (funct == FUNCT_MUL);
  assign prod_next_s  = prod_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
  assign mul_last_s   = (state_r == MUL) && (cnt_r == CNT_W'(WIDTH - 1));
  // The final step waits here until the output register is free.
  assign mul_done_s   = mul_last_s && (!out_valid_r || out_ready);
  assign mul_result_s = prod_next_s;

  // Shift-add multiply datapath: one bit of b per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      prod_r   <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (accept_s && is_mul_s) begin
      cnt_r    <= '0;
      prod_r   <= '0;
      mcand_r  <= a;
      mplier_r <= b;
    end else if ((state_r == MUL) && !mul_last_s) begin
      cnt_r    <= cnt_r + CNT_W'(1);
      prod_r   <= prod_next_s;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
    end
  end
`else
  assign is_mul_s     = 1'b0;
  assign mul_done_s   = 1'b0;
  assign mul_result_s = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_mul_s) begin
          state_nx_s = MUL;
        end else begin
          state_nx_s = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (mul_done_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = MUL;
        end
      end
`endif
      default: state_nx_s = IDLE;
    endcase
  end

  // Output register: load on single-cycle accept or multiply completion, drop on consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      cout_r      <= 1'b0;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid_r <= 1'b1;
      result_r    <= core_result_s;
      cout_r      <= core_cout_s;
      zero_r      <= (core_result_s == {WIDTH{1'b0}});
      overflow_r  <= core_ovf_s;
      illegal_r   <= core_ill_s;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      result_r    <= mul_result_s;
      cout_r      <= 1'b0;
      zero_r      <= (mul_result_s == {WIDTH{1'b0}});
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe; multiply steps compile in only with ALU_MUL_EN.
module tb_alu_pipe;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, cin, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [1:0]   op;
  logic [2:0]   funct;
  logic         cout, zero, overflow, illegal;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [3:0]   flg;  // {cout, zero, overflow, illegal}
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   acc;
  int   nt;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: score a consumed result, log an accept, then step to just after the edge.
  task automatic tick(output bit accepted);
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chkb("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_result"}, result, e.res);
        chk({e.tag, "_flags"}, {60'd0, cout, zero, overflow, illegal}, {60'd0, e.flg});
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [1:0] o, input logic [2:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic [W-1:0] er, input logic [3:0] ef, output int ticks);
    bit got;
    op = o; funct = f; a = x; b = y; cin = c; in_valid = 1'b1;
    pend.tag = tag; pend.res = er; pend.flg = ef;
    ticks = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick(got);
      ticks++;
    end
    chkb({tag, "_accepted"}, got, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 2'b00; funct = 3'b000;
    #1;
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {56'd0, cout, zero, overflow, illegal, 4'd0}, {W{1'b0}});
    chk("rst_result", result, {W{1'b0}});
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chkb("post_rst_in_ready", in_ready, 1'b1);

    // add with both carry and signed overflow, latency check
    send("add", 2'b10, 3'b000, 64'hffffffffffffffff, 64'h8000000000000000, 1'b0,
         64'h7fffffffffffffff, 4'b1010, nt);
    chkb("add_latency", out_valid, 1'b1);
    send("add_cin", 2'b00, 3'b000, 64'h0000000000000005, 64'h0000000000000007, 1'b1,
         64'h000000000000000d, 4'b0000, nt);
    chk("b2b_ticks", 64'(nt), 64'd1);
    send("sub_op", 2'b01, 3'b000, 64'h0123456789abcdef, 64'h0fedcba987654321, 1'b1,
         64'hf13579be02468ace, 4'b0000, nt);
    send("sub_fn", 2'b10, 3'b100, 64'h0123456789abcdef, 64'h0fedcba987654321, 1'b0,
         64'hf13579be02468ace, 4'b0000, nt);
    send("sub_ovf", 2'b01, 3'b000, 64'h8000000000000000, 64'h0000000000000001, 1'b0,
         64'h7fffffffffffffff, 4'b1010, nt);
    send("nand", 2'b10, 3'b110, 64'hffffffffffffffff, 64'h3, 1'b1,
         64'hfffffffffffffffc, 4'b0000, nt);
    send("nor", 2'b10, 3'b111, 64'hffffffffffffffff, 64'h3, 1'b1,
         64'h0, 4'b0100, nt);
    send("op11", 2'b11, 3'b000, 64'hffffffffffffffff, 64'h3, 1'b1,
         64'h0, 4'b0101, nt);
    send("fn001", 2'b10, 3'b001, 64'h1234, 64'h3, 1'b0, 64'h0, 4'b0101, nt);
`ifndef ALU_MUL_EN
    send("fn101_ill", 2'b10, 3'b101, 64'h3, 64'h5, 1'b0, 64'h0, 4'b0101, nt);
`endif
    tick(acc);

    // backpressure: hold the and result, or must wait
    out_ready = 1'b0;
    send("and", 2'b10, 3'b011, 64'hffffffffffffffff, 64'h3, 1'b0,
         64'h0000000000000003, 4'b0000, nt);
    op = 2'b10; funct = 3'b010; in_valid = 1'b1;
    pend.tag = "or"; pend.res = 64'hffffffffffffffff; pend.flg = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      chkb("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold", result, 64'h0000000000000003);
      tick(acc);
      chkb("bp_no_accept", acc, 1'b0);
    end
    out_ready = 1'b1;
    tick(acc);
    chkb("bp_swap_accept", acc, 1'b1);
    out_ready = 1'b0; in_valid = 1'b0;
    chkb("bp_valid_kept", out_valid, 1'b1);
    chk("bp_next", result, 64'hffffffffffffffff);
    out_ready = 1'b1;
    tick(acc);

`ifdef ALU_MUL_EN
    send("mul35", 2'b10, 3'b101, 64'h3, 64'h5, 1'b0, 64'h000000000000000f, 4'b0000, nt);
    for (int i = 1; i <= W; i++) begin
      if (out_valid) chkb("mul_early", out_valid, 1'b0);
      if (in_ready) chkb("mul_in_ready", in_ready, 1'b0);
      tick(acc);
    end
    chkb("mul_latency", out_valid, 1'b1);
    tick(acc);
    send("mulff2", 2'b10, 3'b101, 64'hffffffffffffffff, 64'h2, 1'b0,
         64'hfffffffffffffffe, 4'b0000, nt);
    for (int i = 0; i < W + 4 && !out_valid; i++) tick(acc);
    tick(acc);
    send("mul_abort", 2'b10, 3'b101, 64'h7, 64'h9, 1'b0, 64'h0, 4'b0000, nt);
    for (int i = 0; i < 10; i++) tick(acc);
`else
    out_ready = 1'b0;
    send("held", 2'b00, 3'b000, 64'h1, 64'h2, 1'b0, 64'h3, 4'b0000, nt);
    tick(acc);
`endif

    // asynchronous reset in the middle of an operation
    reset = 1'b1;
    #2;
    chkb("arst_out_valid", out_valid, 1'b0);
    chkb("arst_in_ready", in_ready, 1'b0);
    chk("arst_result", result, {W{1'b0}});
    chk("arst_flags", {60'd0, cout, zero, overflow, illegal}, {W{1'b0}});
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    #1;
    chkb("arst_release_ready", in_ready, 1'b1);
    send("add11", 2'b00, 3'b000, 64'h1, 64'h1, 1'b0, 64'h2, 4'b0000, nt);
    tick(acc);
    tick(acc);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 64-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a one-entry output register with backpressure, and an illegal-op flag.
- Under the optional feature, adds an iterative multi-cycle multiply.
- Sits between the decode stage and writeback in the datapath; op/funct encoding is unchanged from the existing ALU.

Parameters:
- WIDTH, 64, operand/result width in bits (>=8).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; not for override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add only)
- op  in  2  00 add, 01 sub, 10 funct-decoded, 11 illegal
- funct  in  3  000 add, 100 sub, 011 and, 010 or, 110 nand, 111 nor, 101 mul (optional), others illegal
- out_valid  out  1  result register holds unconsumed result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- cout  out  1  carry out
- zero  out  1  result == 0
- overflow  out  1  signed overflow
- illegal  out  1  op/funct not supported

Behaviour:
- Reset (async, active-high): FSM=IDLE; out_valid, result, cout, zero, overflow, illegal all 0; in_ready=0 while reset is high, 1 on the first cycle after release.
- Handshake:
  - Accept on the edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational; out_ready passes through to in_ready.
  - Result fields are stable while out_valid && !out_ready. The result is consumed on the edge where out_valid && out_ready.
  - Accept and consume on the same edge: the new result replaces the old one, and out_valid stays 1.
  - Consume with no accept: out_valid goes to 0.
- Latency: single-cycle ops reach out_valid=1 on the edge following accept. Back-to-back throughput is 1 per cycle when out_ready=1.
- Arithmetic:
  - add: {cout,result} = a + b + cin.
  - sub: {cout,result} = a + ~b + 1. cin is ignored; cout=1 means no borrow.
  - overflow (add/sub): set when the signs of the effective operands are equal and the result sign differs.
- Logic ops (and, or, nand, nor): cout=0, overflow=0.
- zero = (result == 0) for every op, including illegal.
- Illegal op/funct: result=0, cout=0, overflow=0, zero=1, illegal=1, latency 1. illegal=0 for every legal op.
- FSM states: IDLE, MUL.
  - IDLE → MUL on accept of funct 101 when ALU_MUL_EN is defined; all other accepts stay in IDLE.
  - MUL → IDLE after WIDTH iterations.
- Reset during MUL: abort immediately to IDLE, out_valid=0, partial product discarded.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - funct 101 (op=10) is an unsigned multiply giving the low WIDTH bits of a*b.
  - Shift-add, one bit of b per cycle, counter 0..WIDTH-1.
  - in_ready=0 while in MUL.
  - The result register is loaded and out_valid rises on the WIDTH-th edge after accept.
  - cout=0, overflow=0, zero=(result==0).
  - If the output is still held when MUL completes, the FSM stays in MUL on its final count until out_valid clears, then loads.
- Undefined: funct 101 is illegal; the MUL state and counter logic are absent.

Decomposition:
- Package alu_pkg:
  - OP_* constants (2-bit) and FUNCT_* constants (3-bit).
  - alu_state_t enum {IDLE, MUL}.
- Sub-module alu_core: purely combinational add/sub/logic with cout/overflow/illegal decode, parametrised by WIDTH.
- alu_pipe holds the handshake, output register, FSM and multiply datapath.

Test Plan:
1. ADD, WIDTH=64, op=10 funct=000, a=ffffffffffffffff, b=8000000000000000, cin=0 → result 7fffffffffffffff, cout=1, overflow=1, zero=0, out_valid one cycle after accept.
2. SUB, op=01, a=0123456789abcdef, b=0fedcba987654321 → result f13579be02468ace, cout=0, overflow=0; repeat with op=10 funct=100 for an identical result.
3. Logic, a=ffffffffffffffff, b=3:
   - nand → fffffffffffffffc
   - nor → 0000000000000000 with zero=1
   - op=11 → result 0, illegal=1, zero=1
4. Backpressure:
   - Hold out_ready=0, send and(a=ff..ff, b=3) then or(...). Result 0000000000000003 stays stable; in_ready=0; the second op is not accepted.
   - Raise out_ready for 1 cycle → first consumed and second accepted on the same edge; out_valid stays 1; next result is the or value.
5. ALU_MUL_EN, a=3, b=5 → 000000000000000f exactly 64 edges after accept, in_ready=0 throughout. a=ffffffffffffffff, b=2 → fffffffffffffffe, cout=0.
6. Reset mid-op: assert reset 10 cycles into a multiply → out_valid=0 and all outputs 0 immediately (async). After release in_ready=1, and a following add (a=1, b=1) yields 2.
